// File: rtl/ordenador_escritas_rr.sv
// Write-request orderer: arbitrates among NUM_EA expander channels, captures
// the winning channel's neighbour payload, issues it to the evaluator, and
// returns a one-hot completion pulse to the granted channel.
// Handshake: a channel requests by holding ea_atualizar_in[k]. It is granted
// when the block is IDLE and the evaluator is not busy. The payload is
// registered at that edge, and oe_atualizar_out pulses once. The evaluator
// completes with aa_atualizar_ready_in, which is honoured only while waiting.
module ordenador_escritas_rr #(
   parameter int ADDR_WIDTH      = 10,
   parameter int DISTANCIA_WIDTH = 6,
   parameter int NUM_READ_PORTS  = 8,
   parameter int NUM_EA          = 8,
   parameter int CUSTO_WIDTH     = 4,
   parameter int EA_IDX_WIDTH    = 3,
   parameter int ARB_MODE        = 0,
   parameter int TIMEOUT         = 255
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [NUM_EA-1:0]                             ea_atualizar_in,
   input  logic [NUM_READ_PORTS*NUM_EA-1:0]              ea_vizinho_valido_in,
   input  logic [ADDR_WIDTH*NUM_READ_PORTS*NUM_EA-1:0]   ea_endereco_in,
   input  logic [CUSTO_WIDTH*NUM_READ_PORTS*NUM_EA-1:0]  ea_menor_vizinho_in,
   input  logic [DISTANCIA_WIDTH*NUM_READ_PORTS*NUM_EA-1:0] ea_distancia_in,
   input  logic [ADDR_WIDTH*NUM_EA-1:0]                  ea_anterior_in,
   output logic [NUM_EA-1:0]                             ea_atualizar_ready_out,
   input  logic                                          aa_atualizar_ready_in,
   input  logic                                          aa_ocupado_in,
   output logic                                          oe_atualizar_out,
   output logic [NUM_READ_PORTS-1:0]                     oe_vizinho_valido_out,
   output logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]          oe_endereco_out,
   output logic [CUSTO_WIDTH*NUM_READ_PORTS-1:0]         oe_menor_vizinho_out,
   output logic [DISTANCIA_WIDTH*NUM_READ_PORTS-1:0]     oe_distancia_out,
   output logic [ADDR_WIDTH-1:0]                         oe_anterior_out,
   output logic [EA_IDX_WIDTH-1:0]                       oe_canal_out,
   output logic                                          oe_ocupado_out,
   output logic                                          oe_timeout_out
);

   localparam int NR = NUM_READ_PORTS;
   localparam int AW = ADDR_WIDTH * NR;
   localparam int CW = CUSTO_WIDTH * NR;
   localparam int DW = DISTANCIA_WIDTH * NR;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

   state_t                    state_q, state_d;
   logic [EA_IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
   logic [EA_IDX_WIDTH-1:0]   canal_q, canal_d;
   logic [15:0]               cnt_q, cnt_d;
   logic                      atualizar_q, atualizar_d;
   logic                      timeout_q, timeout_d;
   logic [NUM_EA-1:0]         ready_out_q, ready_out_d;
   logic [NR-1:0]             valido_q, valido_d;
   logic [AW-1:0]             endereco_q, endereco_d;
   logic [CW-1:0]             menor_q, menor_d;
   logic [DW-1:0]             dist_q, dist_d;
   logic [ADDR_WIDTH-1:0]     anterior_q, anterior_d;

   logic                      req_any;
   logic [EA_IDX_WIDTH-1:0]   gnt_idx;
   logic [NR-1:0]             sel_valido;
   logic [AW-1:0]             sel_endereco;
   logic [CW-1:0]             sel_menor;
   logic [DW-1:0]             sel_dist;
   logic [ADDR_WIDTH-1:0]     sel_anterior;

   assign req_any = |ea_atualizar_in;

   // Arbiter: rotating search from last_grant+1, or highest index in fixed mode.
   always_comb begin
      logic found;
      int   j;
      found   = 1'b0;
      j       = 0;
      gnt_idx = '0;
      if (ARB_MODE == 1) begin
         for (int i = 0; i < NUM_EA; i++) begin
            if (ea_atualizar_in[i]) gnt_idx = EA_IDX_WIDTH'(i);
         end
      end else begin
         for (int i = 1; i <= NUM_EA; i++) begin
            j = (int'(last_grant_q) + i) % NUM_EA;
            if (!found && ea_atualizar_in[j]) begin
               gnt_idx = EA_IDX_WIDTH'(j);
               found   = 1'b1;
            end
         end
      end
   end

   // Payload mux selecting the granted channel's slice of every bus.
   always_comb begin
      sel_valido   = '0;
      sel_endereco = '0;
      sel_menor    = '0;
      sel_dist     = '0;
      sel_anterior = '0;
      for (int k = 0; k < NUM_EA; k++) begin
         if (gnt_idx == EA_IDX_WIDTH'(k)) begin
            sel_valido   = ea_vizinho_valido_in[k*NR +: NR];
            sel_endereco = ea_endereco_in[k*AW +: AW];
            sel_menor    = ea_menor_vizinho_in[k*CW +: CW];
            sel_dist     = ea_distancia_in[k*DW +: DW];
            sel_anterior = ea_anterior_in[k*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // Next-state logic for the IDLE/WAIT/DONE controller and its registered outputs.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      canal_d      = canal_q;
      cnt_d        = cnt_q;
      atualizar_d  = 1'b0;
      timeout_d    = 1'b0;
      ready_out_d  = '0;
      valido_d     = valido_q;
      endereco_d   = endereco_q;
      menor_d      = menor_q;
      dist_d       = dist_q;
      anterior_d   = anterior_q;
      case (state_q)
         ST_IDLE: begin
            if (req_any && !aa_ocupado_in) begin
               state_d     = ST_WAIT;
               canal_d     = gnt_idx;
               cnt_d       = '0;
               atualizar_d = 1'b1;
               valido_d    = sel_valido;
               endereco_d  = sel_endereco;
               menor_d     = sel_menor;
               dist_d      = sel_dist;
               anterior_d  = sel_anterior;
            end
         end
         ST_WAIT: begin
            // Ready takes priority over an expiring timeout.
            if (aa_atualizar_ready_in) begin
               state_d      = ST_DONE;
               last_grant_d = canal_q;
               for (int k = 0; k < NUM_EA; k++) begin
                  ready_out_d[k] = (canal_q == EA_IDX_WIDTH'(k));
               end
            end else if (16'(cnt_q + 16'd1) == 16'(TIMEOUT)) begin
               // Abort; last_grant is kept so the same channel is retried.
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = 16'(cnt_q + 16'd1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= EA_IDX_WIDTH'(NUM_EA - 1);
         canal_q      <= '0;
         cnt_q        <= '0;
         atualizar_q  <= 1'b0;
         timeout_q    <= 1'b0;
         ready_out_q  <= '0;
         valido_q     <= '0;
         endereco_q   <= '0;
         menor_q      <= '0;
         dist_q       <= '0;
         anterior_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         canal_q      <= canal_d;
         cnt_q        <= cnt_d;
         atualizar_q  <= atualizar_d;
         timeout_q    <= timeout_d;
         ready_out_q  <= ready_out_d;
         valido_q     <= valido_d;
         endereco_q   <= endereco_d;
         menor_q      <= menor_d;
         dist_q       <= dist_d;
         anterior_q   <= anterior_d;
      end
   end

   assign ea_atualizar_ready_out = ready_out_q;
   assign oe_atualizar_out       = atualizar_q;
   assign oe_vizinho_valido_out  = valido_q;
   assign oe_endereco_out        = endereco_q;
   assign oe_menor_vizinho_out   = menor_q;
   assign oe_distancia_out       = dist_q;
   assign oe_anterior_out        = anterior_q;
   assign oe_canal_out           = canal_q;
   assign oe_ocupado_out         = (state_q != ST_IDLE);
   assign oe_timeout_out         = timeout_q;

endmodule

// File: tb/tb_ordenador_escritas_rr.sv
// Directed bench for ordenador_escritas_rr: a round-robin instance and a
// fixed-priority instance share one stimulus stream (both with TIMEOUT=4).
module tb_ordenador_escritas_rr;

   localparam int A = 10;
   localparam int D = 6;
   localparam int R = 8;
   localparam int E = 8;
   localparam int C = 4;
   localparam int X = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [E-1:0]     ea_atualizar_in = '0;
   logic [R*E-1:0]   ea_vizinho_valido_in = '0;
   logic [A*R*E-1:0] ea_endereco_in = '0;
   logic [C*R*E-1:0] ea_menor_vizinho_in = '0;
   logic [D*R*E-1:0] ea_distancia_in = '0;
   logic [A*E-1:0]   ea_anterior_in = '0;
   logic aa_atualizar_ready_in = 1'b0;
   logic aa_ocupado_in = 1'b0;

   logic [E-1:0]   rr_ready, fp_ready;
   logic           rr_atu, fp_atu;
   logic [R-1:0]   rr_valido, fp_valido;
   logic [A*R-1:0] rr_end, fp_end;
   logic [C*R-1:0] rr_menor, fp_menor;
   logic [D*R-1:0] rr_dist, fp_dist;
   logic [A-1:0]   rr_ant, fp_ant;
   logic [X-1:0]   rr_canal, fp_canal;
   logic           rr_ocup, fp_ocup;
   logic           rr_to, fp_to;

   int n_cmp = 0;
   int n_err = 0;

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   ordenador_escritas_rr #(.ARB_MODE(0), .TIMEOUT(4)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .ea_atualizar_in(ea_atualizar_in), .ea_vizinho_valido_in(ea_vizinho_valido_in),
      .ea_endereco_in(ea_endereco_in), .ea_menor_vizinho_in(ea_menor_vizinho_in),
      .ea_distancia_in(ea_distancia_in), .ea_anterior_in(ea_anterior_in),
      .ea_atualizar_ready_out(rr_ready),
      .aa_atualizar_ready_in(aa_atualizar_ready_in), .aa_ocupado_in(aa_ocupado_in),
      .oe_atualizar_out(rr_atu), .oe_vizinho_valido_out(rr_valido),
      .oe_endereco_out(rr_end), .oe_menor_vizinho_out(rr_menor),
      .oe_distancia_out(rr_dist), .oe_anterior_out(rr_ant),
      .oe_canal_out(rr_canal), .oe_ocupado_out(rr_ocup), .oe_timeout_out(rr_to)
   );

   ordenador_escritas_rr #(.ARB_MODE(1), .TIMEOUT(4)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .ea_atualizar_in(ea_atualizar_in), .ea_vizinho_valido_in(ea_vizinho_valido_in),
      .ea_endereco_in(ea_endereco_in), .ea_menor_vizinho_in(ea_menor_vizinho_in),
      .ea_distancia_in(ea_distancia_in), .ea_anterior_in(ea_anterior_in),
      .ea_atualizar_ready_out(fp_ready),
      .aa_atualizar_ready_in(aa_atualizar_ready_in), .aa_ocupado_in(aa_ocupado_in),
      .oe_atualizar_out(fp_atu), .oe_vizinho_valido_out(fp_valido),
      .oe_endereco_out(fp_end), .oe_menor_vizinho_out(fp_menor),
      .oe_distancia_out(fp_dist), .oe_anterior_out(fp_ant),
      .oe_canal_out(fp_canal), .oe_ocupado_out(fp_ocup), .oe_timeout_out(fp_to)
   );

   // Per-channel payload patterns.
   function automatic logic [A*R-1:0] pat_end(int k);
      logic [A*R-1:0] v;
      for (int r = 0; r < R; r++) v[r*A +: A] = A'(k*64 + r*5 + 3);
      return v;
   endfunction
   function automatic logic [C*R-1:0] pat_menor(int k);
      logic [C*R-1:0] v;
      for (int r = 0; r < R; r++) v[r*C +: C] = C'(k + r);
      return v;
   endfunction
   function automatic logic [D*R-1:0] pat_dist(int k);
      logic [D*R-1:0] v;
      for (int r = 0; r < R; r++) v[r*D +: D] = D'(k*7 + r);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_ready"}, 128'(rr_ready), 128'(0));
      chk({tag, "_atu"}, 128'(rr_atu), 128'(0));
      chk({tag, "_valido"}, 128'(rr_valido), 128'(0));
      chk({tag, "_end"}, 128'(rr_end), 128'(0));
      chk({tag, "_menor"}, 128'(rr_menor), 128'(0));
      chk({tag, "_dist"}, 128'(rr_dist), 128'(0));
      chk({tag, "_ant"}, 128'(rr_ant), 128'(0));
      chk({tag, "_canal"}, 128'(rr_canal), 128'(0));
      chk({tag, "_ocup"}, 128'(rr_ocup), 128'(0));
      chk({tag, "_to"}, 128'(rr_to), 128'(0));
   endtask

   initial begin
      int exp_rr[4];
      exp_rr[0] = 0; exp_rr[1] = 3; exp_rr[2] = 5; exp_rr[3] = 0;

      for (int k = 0; k < E; k++) begin
         ea_vizinho_valido_in[k*R +: R] = R'(k*37 + 1);
         ea_endereco_in[k*A*R +: A*R]   = pat_end(k);
         ea_menor_vizinho_in[k*C*R +: C*R] = pat_menor(k);
         ea_distancia_in[k*D*R +: D*R]  = pat_dist(k);
         ea_anterior_in[k*A +: A]       = A'(k*100 + 1);
      end

      // Reset state.
      step();
      all_zero("rst");

      // Single request on channel 2, ready two cycles after issue.
      ea_atualizar_in = 8'b0000_0100;
      rst_n = 1'b1;
      step();
      chk("t1_atu", 128'(rr_atu), 128'(1));
      chk("t1_canal", 128'(rr_canal), 128'(2));
      chk("t1_ocup", 128'(rr_ocup), 128'(1));
      chk("t1_valido", 128'(rr_valido), 128'(8'd75));
      chk("t1_end", 128'(rr_end), 128'(pat_end(2)));
      chk("t1_menor", 128'(rr_menor), 128'(pat_menor(2)));
      chk("t1_dist", 128'(rr_dist), 128'(pat_dist(2)));
      chk("t1_ant", 128'(rr_ant), 128'(10'd201));
      ea_atualizar_in = '0;
      step();
      chk("t1_atu_once", 128'(rr_atu), 128'(0));
      chk("t1_ready_early", 128'(rr_ready), 128'(0));
      aa_atualizar_ready_in = 1'b1;
      step();
      chk("t1_ready", 128'(rr_ready), 128'(8'b0000_0100));
      chk("t1_ocup_done", 128'(rr_ocup), 128'(1));
      step();
      aa_atualizar_ready_in = 1'b0;
      chk("t1_ready_off", 128'(rr_ready), 128'(0));
      chk("t1_idle", 128'(rr_ocup), 128'(0));
      chk("t1_hold_end", 128'(rr_end), 128'(pat_end(2)));
      chk("t1_hold_canal", 128'(rr_canal), 128'(2));

      // Channels 0, 3, 5 held with immediate ready: RR 0,3,5,0 and FP 5,5,5,5.
      rst_n = 1'b0;
      #1;
      ea_atualizar_in = 8'b0010_1001;
      aa_atualizar_ready_in = 1'b1;
      rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         step();
         chk("t2_rr_atu", 128'(rr_atu), 128'(1));
         chk("t2_rr_canal", 128'(rr_canal), 128'(exp_rr[t]));
         chk("t2_rr_end", 128'(rr_end), 128'(pat_end(exp_rr[t])));
         chk("t2_fp_atu", 128'(fp_atu), 128'(1));
         chk("t2_fp_canal", 128'(fp_canal), 128'(5));
         step();
         chk("t2_rr_atu_done", 128'(rr_atu), 128'(0));
         chk("t2_rr_ready", 128'(rr_ready), 128'(8'(1 << exp_rr[t])));
         chk("t2_fp_ready", 128'(fp_ready), 128'(8'b0010_0000));
         step();
         chk("t2_rr_ready_off", 128'(rr_ready), 128'(0));
         chk("t2_rr_atu_idle", 128'(rr_atu), 128'(0));
         chk("t2_rr_idle", 128'(rr_ocup), 128'(0));
      end

      // Timeout of 4 WAIT cycles with no ready, then the same channel is retried.
      rst_n = 1'b0;
      #1;
      aa_atualizar_ready_in = 1'b0;
      ea_atualizar_in = 8'b0100_0000;
      rst_n = 1'b1;
      step();
      chk("t3_atu", 128'(rr_atu), 128'(1));
      chk("t3_canal", 128'(rr_canal), 128'(6));
      for (int t = 0; t < 3; t++) begin
         step();
         chk("t3_wait_ocup", 128'(rr_ocup), 128'(1));
         chk("t3_wait_to", 128'(rr_to), 128'(0));
      end
      step();
      chk("t3_to", 128'(rr_to), 128'(1));
      chk("t3_to_idle", 128'(rr_ocup), 128'(0));
      chk("t3_to_ready", 128'(rr_ready), 128'(0));
      step();
      chk("t3_to_pulse", 128'(rr_to), 128'(0));
      chk("t3_retry_atu", 128'(rr_atu), 128'(1));
      chk("t3_retry_canal", 128'(rr_canal), 128'(6));

      // Busy evaluator holds off channel 1; then ready coincides with timeout.
      rst_n = 1'b0;
      #1;
      aa_ocupado_in = 1'b1;
      ea_atualizar_in = 8'b0000_0010;
      rst_n = 1'b1;
      for (int t = 0; t < 10; t++) begin
         step();
         chk("t4_busy_atu", 128'(rr_atu), 128'(0));
         chk("t4_busy_ocup", 128'(rr_ocup), 128'(0));
      end
      aa_ocupado_in = 1'b0;
      step();
      chk("t4_atu", 128'(rr_atu), 128'(1));
      chk("t4_canal", 128'(rr_canal), 128'(1));
      aa_ocupado_in = 1'b1;
      step();
      step();
      step();
      chk("t4_wait4", 128'(rr_ocup), 128'(1));
      aa_atualizar_ready_in = 1'b1;
      step();
      chk("t4_ready", 128'(rr_ready), 128'(8'b0000_0010));
      chk("t4_no_to", 128'(rr_to), 128'(0));
      aa_atualizar_ready_in = 1'b0;
      aa_ocupado_in = 1'b0;
      step();
      chk("t4_no_to_after", 128'(rr_to), 128'(0));
      chk("t4_ready_off", 128'(rr_ready), 128'(0));

      // Reset during WAIT (last grant was 1, so channel 3 wins here).
      ea_atualizar_in = 8'b0000_1001;
      step();
      chk("t5_canal_pre", 128'(rr_canal), 128'(3));
      chk("t5_ocup_pre", 128'(rr_ocup), 128'(1));
      aa_atualizar_ready_in = 1'b1;
      rst_n = 1'b0;
      #1;
      all_zero("t5_rst");
      step();
      chk("t5_rst_ready", 128'(rr_ready), 128'(0));
      rst_n = 1'b1;
      aa_atualizar_ready_in = 1'b0;
      step();
      chk("t5_atu", 128'(rr_atu), 128'(1));
      chk("t5_canal", 128'(rr_canal), 128'(0));
      chk("t5_fp_canal", 128'(fp_canal), 128'(3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
